// File: rtl/player_pos_2d.sv
// Two-dimensional player position tracker for the grid game.
// Buttons arrive synchronised and debounced. A rising edge on a direction
// moves the player one cell. An optional hold-to-repeat FSM issues further
// moves while a single direction stays held. Win/lose events send the player
// back to the start cell and clear the move count.
//
// Hold FSM handshake: none. The block takes level inputs every clock.
// A request formed at edge k updates the outputs at that same edge k.
// hold_state exposes the hold FSM encoding for debug: 0 = IDLE,
// 1..4 = HOLD(up/down/left/right).
module player_pos_2d #(
  parameter int ROWS          = 8,
  parameter int COLS          = 8,
  parameter int START_ROW     = ROWS - 1,
  parameter int START_COL     = COLS / 2,
  parameter int REPEAT_CYCLES = 0,
  parameter int RW            = $clog2(ROWS),
  parameter int CW            = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          U,
  input  logic          D,
  input  logic          L,
  input  logic          R,
  input  logic          winResult,
  input  logic          loseResult,
  output logic [RW-1:0] rowNumber,
  output logic [CW-1:0] colNumber,
  output logic          moved,
  output logic          reachedTop,
  output logic [15:0]   moveCount,
  output logic [2:0]    hold_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UP   = 3'd1,
    S_DN   = 3'd2,
    S_LF   = 3'd3,
    S_RT   = 3'd4
  } hold_t;

  localparam int HCW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [HCW-1:0] CNT_LAST = HCW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  // Button bit order: [0]=U, [1]=D, [2]=L, [3]=R.
  logic [3:0]     btn;
  logic [3:0]     prev_q;
  logic [3:0]     press;
  logic [3:0]     rep_req;
  logic [3:0]     req;
  logic           clear;
  hold_t          state_q, state_d;
  logic [HCW-1:0] cnt_q, cnt_d;
  logic           v_up, v_dn, h_lf, h_rt;
  logic [RW-1:0]  row_d;
  logic [CW-1:0]  col_d;
  logic           mv_d, top_d;

  assign btn        = {R, L, D, U};
  assign press      = btn & ~prev_q;
  assign clear      = loseResult | winResult;
  assign hold_state = state_q;

  function automatic logic [3:0] dir_mask(input hold_t s);
    case (s)
      S_UP:    dir_mask = 4'b0001;
      S_DN:    dir_mask = 4'b0010;
      S_LF:    dir_mask = 4'b0100;
      S_RT:    dir_mask = 4'b1000;
      default: dir_mask = 4'b0000;
    endcase
  endfunction

  // Hold FSM state and repeat counter; win/lose behave like reset here.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Hold FSM next state: enter on a lone fresh press, leave on any change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (REPEAT_CYCLES > 0) begin
      if (state_q == S_IDLE) begin
        cnt_d = '0;
        if (btn == press) begin
          case (press)
            4'b0001: state_d = S_UP;
            4'b0010: state_d = S_DN;
            4'b0100: state_d = S_LF;
            4'b1000: state_d = S_RT;
            default: state_d = S_IDLE;
          endcase
        end
      end else if (btn == dir_mask(state_q)) begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + HCW'(1);
      end else begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    end
  end

  // Hold FSM output: one repeat request when the held count expires.
  always_comb begin
    rep_req = 4'b0000;
    if (REPEAT_CYCLES > 0 && state_q != S_IDLE &&
        btn == dir_mask(state_q) && cnt_q == CNT_LAST)
      rep_req = dir_mask(state_q);
  end

  // Resolve requests: opposing buttons cancel, vertical beats horizontal,
  // edge-of-grid moves are swallowed without wrap.
  always_comb begin
    req   = press | rep_req;
    v_up  = req[0] & ~(U & D);
    v_dn  = req[1] & ~(U & D);
    h_lf  = req[2] & ~(L & R);
    h_rt  = req[3] & ~(L & R);
    row_d = rowNumber;
    col_d = colNumber;
    mv_d  = 1'b0;
    top_d = 1'b0;
    if (v_up || v_dn) begin
      if (v_up && rowNumber != '0) begin
        row_d = rowNumber - RW'(1);
        mv_d  = 1'b1;
        top_d = (rowNumber == RW'(1));
      end else if (v_dn && rowNumber != RW'(ROWS - 1)) begin
        row_d = rowNumber + RW'(1);
        mv_d  = 1'b1;
      end
    end else if (h_lf && colNumber != '0) begin
      col_d = colNumber - CW'(1);
      mv_d  = 1'b1;
    end else if (h_rt && colNumber != CW'(COLS - 1)) begin
      col_d = colNumber + CW'(1);
      mv_d  = 1'b1;
    end
  end

  // Position, pulses, saturating move count and previous button samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      rowNumber  <= RW'(START_ROW);
      colNumber  <= CW'(START_COL);
      moved      <= 1'b0;
      reachedTop <= 1'b0;
      moveCount  <= 16'h0000;
      prev_q     <= 4'b1111;
    end else if (clear) begin
      rowNumber  <= RW'(START_ROW);
      colNumber  <= CW'(START_COL);
      moved      <= 1'b0;
      reachedTop <= 1'b0;
      moveCount  <= 16'h0000;
      prev_q     <= btn;
    end else begin
      rowNumber  <= row_d;
      colNumber  <= col_d;
      moved      <= mv_d;
      reachedTop <= top_d;
      if (mv_d && moveCount != 16'hFFFF)
        moveCount <= moveCount + 16'h0001;
      prev_q     <= btn;
    end
  end

endmodule

// File: tb/tb_player_pos_2d.sv
// Bench for player_pos_2d: directed scenarios followed by random button
// activity, checked against a behavioural model through an expected queue.
module tb_player_pos_2d;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int REP  = 4;
  localparam int W    = 25;

  logic        clk, reset, U, D, L, R, winResult, loseResult;
  logic [2:0]  rowNumber, colNumber, hold_state;
  logic        moved, reachedTop;
  logic [15:0] moveCount;

  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state.
  int         m_row, m_col, m_cnt, m_hdir, m_htime;
  bit         m_moved, m_top;
  logic [3:0] m_prev;

  player_pos_2d #(.ROWS(ROWS), .COLS(COLS), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .reset(reset), .U(U), .D(D), .L(L), .R(R),
    .winResult(winResult), .loseResult(loseResult),
    .rowNumber(rowNumber), .colNumber(colNumber), .moved(moved),
    .reachedTop(reachedTop), .moveCount(moveCount), .hold_state(hold_state)
  );

  // Clock and initial reset levels.
  initial begin
    clk = 1'b0; reset = 1'b1; U = 0; D = 0; L = 0; R = 0;
    winResult = 0; loseResult = 0;
  end
  always #5 clk = ~clk;

  // Behavioural model: one call per clock edge with that edge's inputs.
  task automatic model(input logic [3:0] b, input bit rst, input bit win, input bit lose);
    logic [3:0] press, req, one;
    int rep, dr, dc, nr, nc;
    one = 4'b0001;
    m_moved = 0; m_top = 0;
    if (rst || win || lose) begin
      m_row = ROWS - 1; m_col = COLS / 2; m_cnt = 0;
      m_hdir = -1; m_htime = 0;
      m_prev = rst ? 4'b1111 : b;
      return;
    end
    press = b & ~m_prev;
    m_prev = b;
    rep = -1;
    if (m_hdir >= 0) begin
      if (b == (one << m_hdir)) begin
        if (m_htime == REP - 1) begin rep = m_hdir; m_htime = 0; end
        else m_htime++;
      end else begin
        m_hdir = -1; m_htime = 0;
      end
    end else if ($countones(b) == 1 && press == b) begin
      for (int i = 0; i < 4; i++) if (b[i]) m_hdir = i;
      m_htime = 0;
    end
    req = press;
    if (rep >= 0) req = req | (one << rep);
    dr = 0; dc = 0;
    if (!(b[0] && b[1]) && (req[0] || req[1])) dr = req[0] ? -1 : 1;
    else if (!(b[2] && b[3]) && (req[2] || req[3])) dc = req[2] ? -1 : 1;
    nr = m_row + dr;
    nc = m_col + dc;
    if ((dr != 0 || dc != 0) && nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS) begin
      m_moved = 1;
      m_top = (dr == -1 && nr == 0);
      m_row = nr; m_col = nc;
      if (m_cnt < 65535) m_cnt++;
    end
  endtask

  // Driver: apply inputs for one cycle, then log the expected response.
  task automatic step(input logic [3:0] b, input bit rst = 0, input bit win = 0, input bit lose = 0);
    @(negedge clk);
    U = b[0]; D = b[1]; L = b[2]; R = b[3];
    reset = rst; winResult = win; loseResult = lose;
    @(posedge clk);
    model(b, rst, win, lose);
    exp_q.push_back({3'(m_row), 3'(m_col), m_moved, m_top, 16'(m_cnt), (m_hdir < 0)});
  endtask

  task automatic tap(input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) begin step(b); step(4'b0000); end
  endtask

  task automatic hold(input logic [3:0] b, input int n);
    for (int i = 0; i < n; i++) step(b);
  endtask

  // Monitor / scoreboard: outputs are valid every cycle, checked after each edge.
  always @(posedge clk) begin
    logic [W-1:0] e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {rowNumber, colNumber, moved, reachedTop, moveCount, (hold_state == 3'd0)};
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t: got row=%0d col=%0d moved=%0b top=%0b cnt=%0d idle=%0b, want row=%0d col=%0d moved=%0b top=%0b cnt=%0d idle=%0b",
                 $time, a[24:22], a[21:19], a[18], a[17], a[16:1], a[0],
                 e[24:22], e[21:19], e[18], e[17], e[16:1], e[0]);
      end
    end
  end

  // Stimulus sequence.
  initial begin
    logic [3:0] b;
    // Button held through reset must be released before it acts.
    step(4'b0001, 1); step(4'b0001, 1);
    hold(4'b0001, 3);
    step(4'b0000); step(4'b0001); step(4'b0000); step(4'b0000);
    // Walk to the top row and press past it.
    step(4'b0000, 1);
    tap(4'b0001, 9);
    // Left/right including both edges, then vertical beating horizontal.
    step(4'b0000, 1);
    tap(4'b0100, 5);
    tap(4'b1000, 8);
    tap(4'b0101, 1);
    // Opposing buttons and a bottom-edge down press with right.
    step(4'b0000, 1);
    tap(4'b0011, 1);
    tap(4'b1010, 1);
    // Auto-repeat from column 0, release, and cancel by a second button.
    step(4'b0000, 1);
    tap(4'b0100, 4);
    hold(4'b1000, 13);
    hold(4'b0000, 3);
    hold(4'b1000, 3);
    hold(4'b1100, 4);
    hold(4'b1000, 6);
    hold(4'b0000, 2);
    // Lose, win and reset with a simultaneous press / mid-hold.
    step(4'b0000, 1);
    tap(4'b0001, 4); tap(4'b1000, 2);
    step(4'b0001, 0, 0, 1); step(4'b0000);
    tap(4'b0001, 4); tap(4'b1000, 2);
    step(4'b0001, 0, 1, 0); step(4'b0000);
    hold(4'b1000, 6);
    step(4'b1000, 0, 1, 1);
    hold(4'b1000, 3);
    step(4'b0000);
    hold(4'b0100, 6);
    step(4'b0100, 1);
    hold(4'b0000, 2);
    hold(4'b0100, 9);
    step(4'b0000);
    // Random button activity with occasional win/lose/reset.
    b = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) b = b ^ (4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) b = 4'b0000;
      case ($urandom_range(0, 99))
        0:       step(b, 1, 0, 0);
        1:       step(b, 0, 1, 0);
        2:       step(b, 0, 0, 1);
        default: step(b);
      endcase
    end
    // Drain the queue within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
